instr_fetch_split: RTL and testbench
====================================

// Module: instr_fetch_split
// PURPOSE
//  Fetch-side counterpart of the control-signal FSM. Consumes its PC/instruction load strobes, owns PC and MAR.
//  Reads instruction words from program memory over a req/ack handshake. Splits the first word into
//  opcode/register fields for the controller; captures a second word as the immediate for two-word opcodes.
// PARAMETERS
//  ADDR_W    16      program-memory address / PC width
//  DATA_W    16      instruction word width
//  RESET_PC  16'h0000 PC value after reset
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  cs_pc_load   in   1       copy PC into MAR (address for next read)
//  cs_ins_load  in   1       start read at MAR; capture returned word
//  cs_pc_inc    in   1       PC <= PC + 1
//  jmp_en       in   1       PC <= jmp_addr (branch from execute stage)
//  jmp_addr     in   ADDR_W  branch target
//  mem_addr     out  ADDR_W  program-memory address (= MAR)
//  mem_req      out  1       read request, held until mem_ack
//  mem_ack      in   1       read data valid this cycle
//  mem_rdata    in   DATA_W  read data
//  CS_opcode    out  4       IR[15:12], to control FSM
//  alu_mode     out  2       IR[11:10]
//  op1_addr     out  3       IR[9:7]
//  op2_addr     out  3       IR[6:4]
//  imm          out  DATA_W  second-word immediate
//  pc           out  ADDR_W  current PC
//  fetch_done   out  1       one-cycle pulse: word captured
//  fetch_busy   out  1       read in flight
//  fetch_err    out  1       sticky: cs_ins_load while busy
// BEHAVIOUR
//  Reset (async, rst_n=0): PC=RESET_PC, MAR=RESET_PC, IR=0, imm=0, word_sel=0, state=IDLE,
//   mem_req=0, fetch_done=0, fetch_busy=0, fetch_err=0. mem_req drops immediately even mid-read.
//  FSM IDLE -> REQ on cs_ins_load. REQ: mem_req=1, fetch_busy=1; stay until mem_ack.
//   On mem_ack: capture mem_rdata -> CAPT. CAPT: fetch_done=1 for exactly one cycle -> IDLE.
//   Latency: cs_ins_load at cycle N, mem_ack at N+1 earliest, fetch_done at N+2, fields valid from N+2.
//  Capture routing: word_sel=0 -> IR<=rdata; if rdata[15:12] in TWO_WORD set (0001 MVI, 0010 LDA)
//   set word_sel=1. word_sel=1 -> imm<=rdata, IR unchanged, word_sel<=0.
//  cs_ins_load while state!=IDLE: ignored, fetch_err<=1 (cleared only by reset).
//  cs_ins_load and cs_pc_load same cycle: MAR updated first, read uses new PC (MAR bypass).
//  PC update priority: jmp_en > cs_pc_inc. PC wraps 16'hFFFF -> 16'h0000. jmp_en also clears word_sel.
//  PC changes during a read do not alter mem_addr (MAR stable while mem_req=1); cs_pc_load while
//   busy is ignored.
//  mem_ack while IDLE: ignored. mem_rdata sampled only on mem_ack in REQ.
//  Field outputs are registered slices of IR; imm/IR hold until next capture.
// STRUCTURE
//  cpu_pkg: opcode constants (OP_MOV=0000, OP_MVI=0001, OP_LDA=0010), is_two_word() function,
//   IR field bit positions, fetch state enum (IDLE/REQ/CAPT).
//  Sub-module pc_counter: PC register with load/inc/wrap and priority; rest inline.
// TESTING
//  Reset: rst_n low mid-REQ -> mem_req=0 same cycle, pc=0, all flags 0.
//  MOV fetch: pc_load, ins_load, ack 1 cycle later with 16'h0_A_B0 (rdata=16'h0AB0) ->
//   CS_opcode=0, op1_addr=5, op2_addr=3, fetch_done pulse at N+2, word_sel stays 0.
//  MVI two-word: word1=16'h1280, inc, second fetch word2=16'hBEEF -> CS_opcode=1, imm=16'hBEEF,
//   IR unchanged after second capture, word_sel back to 0.
//  Wait states: ack delayed 5 cycles -> mem_req held, mem_addr stable, fetch_busy=1 throughout.
//  Overlap/PC: ins_load during REQ -> fetch_err=1, no second read; PC=16'hFFFF + inc -> 0;
//   jmp_en=1 with jmp_addr=16'h0040 and cs_pc_inc same cycle -> pc=16'h0040.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction-fetch slice.
//   - opcode constants for the opcodes the fetch path must recognise
//   - IR field bit positions used to split the first instruction word
//   - fetch FSM state encoding
//   - is_two_word(): true for opcodes followed by an immediate word
package cpu_pkg;

   localparam logic [3:0] OP_MOV = 4'b0000;
   localparam logic [3:0] OP_MVI = 4'b0001;
   localparam logic [3:0] OP_LDA = 4'b0010;

   localparam int unsigned IR_OPC_HI = 15;
   localparam int unsigned IR_OPC_LO = 12;
   localparam int unsigned IR_ALU_HI = 11;
   localparam int unsigned IR_ALU_LO = 10;
   localparam int unsigned IR_OP1_HI = 9;
   localparam int unsigned IR_OP1_LO = 7;
   localparam int unsigned IR_OP2_HI = 6;
   localparam int unsigned IR_OP2_LO = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2
   } fetch_state_e;

   function automatic logic is_two_word(input logic [3:0] opc);
      return (opc == OP_MVI) || (opc == OP_LDA);
   endfunction

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter register.
//   clk, rst_n  : clock, asynchronous active-low reset (PC <= RESET_PC)
//   load        : PC <= load_val (branch target), has priority over inc
//   load_val    : branch target
//   inc         : PC <= PC + 1, wraps from all-ones to zero
//   pc          : current PC
module pc_counter #(
   parameter int unsigned           ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_split.sv
// instr_fetch_split: fetch side of the control path.
//   Owns PC (via pc_counter) and MAR, reads instruction words from program
//   memory over a req/ack handshake, splits the first word into
//   opcode/alu_mode/operand fields and captures the following word as the
//   immediate for two-word opcodes (MVI, LDA).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cs_pc_load           MAR <= PC (ignored while a read is in flight)
//   cs_ins_load          start a read at MAR (error if not idle)
//   cs_pc_inc, jmp_en,   PC increment / branch (branch wins)
//   jmp_addr
//   mem_addr, mem_req,   program-memory read port; mem_req held until ack
//   mem_ack, mem_rdata
//   CS_opcode, alu_mode, fields of the captured instruction register
//   op1_addr, op2_addr
//   imm                  second-word immediate
//   pc                   current PC
//   fetch_done           one-cycle pulse after a word is captured
//   fetch_busy           read in flight
//   fetch_err            sticky: cs_ins_load seen while not idle
module instr_fetch_split
   import cpu_pkg::*;
#(
   parameter int unsigned           ADDR_W   = 16,
   parameter int unsigned           DATA_W   = 16,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_pc_load,
   input  logic              cs_ins_load,
   input  logic              cs_pc_inc,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        CS_opcode,
   output logic [1:0]        alu_mode,
   output logic [2:0]        op1_addr,
   output logic [2:0]        op2_addr,
   output logic [DATA_W-1:0] imm,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_done,
   output logic              fetch_busy,
   output logic              fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic              word_sel_q, word_sel_d;
   logic              mem_req_q, mem_req_d;
   logic              fetch_busy_q, fetch_busy_d;
   logic              fetch_done_q, fetch_done_d;
   logic              fetch_err_q, fetch_err_d;
   logic [ADDR_W-1:0] pc_cur;

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (jmp_en),
      .load_val (jmp_addr),
      .inc      (cs_pc_inc),
      .pc       (pc_cur)
   );

   always_comb begin
      state_d    = state_q;
      mar_d      = mar_q;
      ir_d       = ir_q;
      imm_d      = imm_q;
      word_sel_d = word_sel_q;
      fetch_err_d = fetch_err_q;

      case (state_q)
         IDLE: begin
            // MAR and state update on the same edge, so a same-cycle
            // pc_load + ins_load issues the read at the freshly loaded PC.
            if (cs_pc_load) begin
               mar_d = pc_cur;
            end
            if (cs_ins_load) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (!word_sel_q) begin
                  ir_d = mem_rdata;
                  word_sel_d = is_two_word(mem_rdata[IR_OPC_HI:IR_OPC_LO]);
               end else begin
                  imm_d      = mem_rdata;
                  word_sel_d = 1'b0;
               end
               state_d = CAPT;
            end
         end
         CAPT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cs_ins_load && (state_q != IDLE)) begin
         fetch_err_d = 1'b1;
      end

      // A branch abandons any pending immediate word.
      if (jmp_en) begin
         word_sel_d = 1'b0;
      end

      // Outputs are registered from the next state so they align with it.
      mem_req_d    = (state_d == REQ);
      fetch_busy_d = (state_d == REQ);
      fetch_done_d = (state_d == CAPT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mar_q        <= RESET_PC;
         ir_q         <= '0;
         imm_q        <= '0;
         word_sel_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         fetch_busy_q <= 1'b0;
         fetch_done_q <= 1'b0;
         fetch_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         mar_q        <= mar_d;
         ir_q         <= ir_d;
         imm_q        <= imm_d;
         word_sel_q   <= word_sel_d;
         mem_req_q    <= mem_req_d;
         fetch_busy_q <= fetch_busy_d;
         fetch_done_q <= fetch_done_d;
         fetch_err_q  <= fetch_err_d;
      end
   end

   assign mem_addr   = mar_q;
   assign mem_req    = mem_req_q;
   assign fetch_busy = fetch_busy_q;
   assign fetch_done = fetch_done_q;
   assign fetch_err  = fetch_err_q;
   assign pc         = pc_cur;
   assign imm        = imm_q;
   assign CS_opcode  = ir_q[IR_OPC_HI:IR_OPC_LO];
   assign alu_mode   = ir_q[IR_ALU_HI:IR_ALU_LO];
   assign op1_addr   = ir_q[IR_OP1_HI:IR_OP1_LO];
   assign op2_addr   = ir_q[IR_OP2_HI:IR_OP2_LO];

endmodule

// File: tb/tb_instr_fetch_split.sv
// Self-checking bench for instr_fetch_split. Expected field values come from
// a small bench-side model of IR/imm/word routing and are queued when each
// fetch is driven, then popped when fetch_done is seen.
module tb_instr_fetch_split;

   logic        clk;
   logic        rst_n;
   logic        cs_pc_load;
   logic        cs_ins_load;
   logic        cs_pc_inc;
   logic        jmp_en;
   logic [15:0] jmp_addr;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [3:0]  CS_opcode;
   logic [1:0]  alu_mode;
   logic [2:0]  op1_addr;
   logic [2:0]  op2_addr;
   logic [15:0] imm;
   logic [15:0] pc;
   logic        fetch_done;
   logic        fetch_busy;
   logic        fetch_err;

   instr_fetch_split #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .RESET_PC (16'h0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cs_pc_load  (cs_pc_load),
      .cs_ins_load (cs_ins_load),
      .cs_pc_inc   (cs_pc_inc),
      .jmp_en      (jmp_en),
      .jmp_addr    (jmp_addr),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .CS_opcode   (CS_opcode),
      .alu_mode    (alu_mode),
      .op1_addr    (op1_addr),
      .op2_addr    (op2_addr),
      .imm         (imm),
      .pc          (pc),
      .fetch_done  (fetch_done),
      .fetch_busy  (fetch_busy),
      .fetch_err   (fetch_err)
   );

   typedef struct packed {
      logic [3:0]  opc;
      logic [1:0]  alu;
      logic [2:0]  op1;
      logic [2:0]  op2;
      logic [15:0] imm;
   } exp_t;

   exp_t sb[$];

   int errs   = 0;
   int checks = 0;

   // bench model
   logic [15:0] m_pc, m_mar, m_ir, m_imm;
   logic        m_ws;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_pc = 16'h0000; m_mar = 16'h0000; m_ir = 16'h0000; m_imm = 16'h0000; m_ws = 1'b0;
      sb.delete();
   endtask

   task automatic model_capture(input logic [15:0] w);
      exp_t e;
      logic [3:0] o;
      if (!m_ws) begin
         m_ir = w;
         o = w[15:12];
         m_ws = (o == 4'b0001) || (o == 4'b0010);
      end else begin
         m_imm = w;
         m_ws = 1'b0;
      end
      e.opc = m_ir[15:12];
      e.alu = m_ir[11:10];
      e.op1 = m_ir[9:7];
      e.op2 = m_ir[6:4];
      e.imm = m_imm;
      sb.push_back(e);
   endtask

   task automatic fetch(input logic pcl, input int waits, input logic [15:0] w);
      exp_t e;
      @(negedge clk);
      cs_pc_load = pcl; cs_ins_load = 1'b1;
      if (pcl) m_mar = m_pc;
      model_capture(w);
      @(negedge clk);
      cs_pc_load = 1'b0; cs_ins_load = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         checks++;
         if (mem_req !== 1'b1) begin errs++; $display("FAIL fetch_req: got %b want 1 (cycle %0d)", mem_req, i); end
         checks++;
         if (mem_addr !== m_mar) begin errs++; $display("FAIL fetch_addr: got %h want %h", mem_addr, m_mar); end
         checks++;
         if (fetch_busy !== 1'b1) begin errs++; $display("FAIL fetch_busy: got %b want 1", fetch_busy); end
         checks++;
         if (fetch_done !== 1'b0) begin errs++; $display("FAIL early_done: got %b want 0", fetch_done); end
         if (i < waits) @(negedge clk);
      end
      mem_ack = 1'b1; mem_rdata = w;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'hxxxx;
      checks++;
      if (fetch_done !== 1'b1) begin errs++; $display("FAIL done_pulse: got %b want 1", fetch_done); end
      checks++;
      if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
         errs++; $display("FAIL req_drop: got req=%b busy=%b want 0/0", mem_req, fetch_busy);
      end
      if (sb.size() == 0) begin
         checks++; errs++; $display("FAIL scoreboard: empty at fetch_done");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({CS_opcode, alu_mode, op1_addr, op2_addr, imm} !== e) begin
            errs++;
            $display("FAIL fields: got opc=%h alu=%h op1=%h op2=%h imm=%h want opc=%h alu=%h op1=%h op2=%h imm=%h",
                     CS_opcode, alu_mode, op1_addr, op2_addr, imm, e.opc, e.alu, e.op1, e.op2, e.imm);
         end
      end
      @(negedge clk);
      checks++;
      if (fetch_done !== 1'b0) begin errs++; $display("FAIL done_width: got %b want 0", fetch_done); end
   endtask

   task automatic pc_inc();
      @(negedge clk); cs_pc_inc = 1'b1;
      m_pc = m_pc + 16'd1;
      @(negedge clk); cs_pc_inc = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_req, fetch_done, fetch_busy, fetch_err} !== 4'b0000) begin
         errs++; $display("FAIL reset_flags: got %b want 0000", {mem_req, fetch_done, fetch_busy, fetch_err});
      end
      checks++;
      if (pc !== 16'h0000 || mem_addr !== 16'h0000 || imm !== 16'h0000 || CS_opcode !== 4'h0) begin
         errs++; $display("FAIL reset_regs: got pc=%h addr=%h imm=%h opc=%h want 0", pc, mem_addr, imm, CS_opcode);
      end
      rst_n = 1'b1;
      // reset while a read is pending, with PC moved and fetch_err set
      pc_inc();
      @(negedge clk); cs_ins_load = 1'b1;
      @(negedge clk); cs_ins_load = 1'b1;
      @(negedge clk); cs_ins_load = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || fetch_err !== 1'b1) begin
         errs++; $display("FAIL pre_reset: got req=%b err=%b want 1/1", mem_req, fetch_err);
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (mem_req !== 1'b0) begin errs++; $display("FAIL async_req_drop: got %b want 0", mem_req); end
      checks++;
      if ({fetch_done, fetch_busy, fetch_err} !== 3'b000 || pc !== 16'h0000) begin
         errs++; $display("FAIL async_reset: got flags=%b pc=%h want 000/0000", {fetch_done, fetch_busy, fetch_err}, pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mov();
      fetch(1'b1, 0, 16'h0AB0);
      checks++;
      if (CS_opcode !== 4'h0 || alu_mode !== 2'd2 || op1_addr !== 3'd5 || op2_addr !== 3'd3) begin
         errs++; $display("FAIL mov_fields: got %h/%h/%h/%h want 0/2/5/3", CS_opcode, alu_mode, op1_addr, op2_addr);
      end
      checks++;
      if (fetch_err !== 1'b0) begin errs++; $display("FAIL mov_err: got %b want 0", fetch_err); end
   endtask

   task automatic test_mvi_two_word();
      pc_inc();
      fetch(1'b1, 0, 16'h1280);
      pc_inc();
      fetch(1'b1, 0, 16'hBEEF);
      checks++;
      if (CS_opcode !== 4'h1 || imm !== 16'hBEEF || op1_addr !== 3'd5) begin
         errs++; $display("FAIL mvi: got opc=%h imm=%h op1=%h want 1/BEEF/5", CS_opcode, imm, op1_addr);
      end
      // next word must route to IR again
      pc_inc();
      fetch(1'b1, 0, 16'h3120);
   endtask

   task automatic test_wait_states();
      pc_inc();
      fetch(1'b1, 5, 16'h4C50);
   endtask

   task automatic test_ack_idle();
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      @(negedge clk); mem_ack = 1'b0;
      checks++;
      if (fetch_done !== 1'b0 || fetch_busy !== 1'b0 || CS_opcode !== m_ir[15:12] || imm !== m_imm) begin
         errs++; $display("FAIL ack_idle: got done=%b busy=%b opc=%h imm=%h want 0/0/%h/%h",
                          fetch_done, fetch_busy, CS_opcode, imm, m_ir[15:12], m_imm);
      end
   endtask

   task automatic test_overlap();
      exp_t e;
      @(negedge clk); cs_pc_load = 1'b1; cs_ins_load = 1'b1;
      m_mar = m_pc;
      model_capture(16'h6D10);
      @(negedge clk);
      cs_ins_load = 1'b1; cs_pc_load = 1'b1; cs_pc_inc = 1'b1;
      m_pc = m_pc + 16'd1;
      @(negedge clk);
      cs_ins_load = 1'b0; cs_pc_load = 1'b0; cs_pc_inc = 1'b0;
      checks++;
      if (fetch_err !== 1'b1) begin errs++; $display("FAIL overlap_err: got %b want 1", fetch_err); end
      checks++;
      if (mem_addr !== m_mar || pc !== m_pc || mem_req !== 1'b1) begin
         errs++; $display("FAIL overlap_mar: got addr=%h pc=%h req=%b want %h/%h/1", mem_addr, pc, mem_req, m_mar, m_pc);
      end
      mem_ack = 1'b1; mem_rdata = 16'h6D10;
      @(negedge clk); mem_ack = 1'b0;
      checks++;
      if (fetch_done !== 1'b1) begin errs++; $display("FAIL overlap_done: got %b want 1", fetch_done); end
      e = sb.pop_front();
      checks++;
      if ({CS_opcode, alu_mode, op1_addr, op2_addr, imm} !== e) begin
         errs++; $display("FAIL overlap_fields: got %h want %h", {CS_opcode, alu_mode, op1_addr, op2_addr, imm}, e);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || fetch_done !== 1'b0) begin
            errs++; $display("FAIL no_second_read: got req=%b done=%b want 0/0", mem_req, fetch_done);
         end
      end
      checks++;
      if (fetch_err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b want 1", fetch_err); end
   endtask

   task automatic test_pc();
      @(negedge clk); jmp_en = 1'b1; jmp_addr = 16'hFFFF;
      @(negedge clk); jmp_en = 1'b0;
      m_pc = 16'hFFFF;
      checks++;
      if (pc !== 16'hFFFF) begin errs++; $display("FAIL jmp: got %h want FFFF", pc); end
      pc_inc();
      checks++;
      if (pc !== 16'h0000) begin errs++; $display("FAIL pc_wrap: got %h want 0000", pc); end
      @(negedge clk); jmp_en = 1'b1; jmp_addr = 16'h0040; cs_pc_inc = 1'b1;
      @(negedge clk); jmp_en = 1'b0; cs_pc_inc = 1'b0;
      m_pc = 16'h0040;
      checks++;
      if (pc !== 16'h0040) begin errs++; $display("FAIL jmp_prio: got %h want 0040", pc); end
      // LDA first word, then a branch: the next word must land in IR
      fetch(1'b1, 1, 16'h2AAA);
      @(negedge clk); jmp_en = 1'b1; jmp_addr = 16'h0100;
      @(negedge clk); jmp_en = 1'b0;
      m_pc = 16'h0100; m_ws = 1'b0;
      fetch(1'b1, 0, 16'h5000);
      checks++;
      if (CS_opcode !== 4'h5) begin errs++; $display("FAIL jmp_clears_ws: got %h want 5", CS_opcode); end
   endtask

   initial begin
      cs_pc_load = 1'b0; cs_ins_load = 1'b0; cs_pc_inc = 1'b0;
      jmp_en = 1'b0; jmp_addr = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;
      test_reset();
      test_mov();
      test_mvi_two_word();
      test_wait_states();
      test_ack_idle();
      test_overlap();
      test_pc();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
